// File: rtl/adder_secded_pkg.sv
// adder_secded_pkg
//   Shared definitions for the SEC-DED protected adder pipeline.
//   Codeword bit i is Hamming position i. Power-of-two positions hold parity,
//   the other positions hold data LSB-first, and bit 0 is the overall parity.
//   The helpers use fixed maximum widths (MAXK data bits, MAXCW codeword
//   bits). Callers pass the real data width and keep only the low bits.
package adder_secded_pkg;

   localparam int MAXK  = 32;
   localparam int MAXCW = 64;

   // Smallest r such that 2^r >= k + r + 1
   function automatic int calc_npar(input int k);
      int r;
      r = 1;
      while ((1 << r) < k + r + 1) r++;
      return r;
   endfunction

   function automatic logic is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // Hamming position of data bit j (j-th non-power-of-two position)
   function automatic int data_pos(input int j);
      int pos;
      int cnt;
      pos = 0;
      cnt = -1;
      while (cnt < j) begin
         pos++;
         if (!is_pow2(pos)) cnt++;
      end
      return pos;
   endfunction

   function automatic logic [MAXCW-1:0] enc(input logic [MAXK-1:0] data, input int k);
      logic [MAXCW-1:0] cw;
      logic             par;
      int               n;
      cw = '0;
      n  = k + calc_npar(k);
      for (int j = 0; j < MAXK; j++)
         if (j < k) cw[data_pos(j)] = data[j];
      // Parity positions are still zero while their own sum is formed,
      // so they can be left inside the XOR.
      for (int i = 0; i < 6; i++) begin
         if ((1 << i) <= n) begin
            par = 1'b0;
            for (int p = 1; p < MAXCW; p++)
               if (p <= n && (p & (1 << i)) != 0) par ^= cw[p];
            cw[1 << i] = par;
         end
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   // XOR of the indices of all set bits in positions 1..n
   function automatic logic [7:0] calc_syndrome(input logic [MAXCW-1:0] cw, input int n);
      logic [7:0] s;
      s = '0;
      for (int p = 1; p < MAXCW; p++)
         if (p <= n && cw[p]) s ^= 8'(p);
      return s;
   endfunction

   function automatic logic [MAXK-1:0] extract(input logic [MAXCW-1:0] cw, input int k);
      logic [MAXK-1:0] d;
      d = '0;
      for (int j = 0; j < MAXK; j++)
         if (j < k) d[j] = cw[data_pos(j)];
      return d;
   endfunction

endpackage

// File: rtl/secded_decoder.sv
// secded_decoder
//   Combinational extended-Hamming decoder.
//   cw        : NCODE-bit codeword (bit 0 = overall parity)
//   data      : corrected data, or the raw data bits when uncorrectable
//   syndrome  : Hamming syndrome (XOR of set-bit positions)
//   corrected : single error repaired (includes an overall-parity-only error)
//   uncorr    : double error, or odd error pattern pointing past the codeword
module secded_decoder
   import adder_secded_pkg::*;
#(
   parameter  int K     = 8,
   localparam int NPAR  = calc_npar(K),
   localparam int NCODE = K + NPAR + 1
) (
   input  logic [NCODE-1:0] cw,
   output logic [K-1:0]     data,
   output logic [NPAR-1:0]  syndrome,
   output logic             corrected,
   output logic             uncorr
);

   logic [MAXCW-1:0] cw_ext;
   logic [MAXCW-1:0] fixed;
   logic [7:0]       s_full;
   logic [MAXK-1:0]  data_full;
   logic             p_all;
   logic             unused_bits;

   always_comb begin
      cw_ext    = MAXCW'(cw);
      s_full    = calc_syndrome(cw_ext, K + NPAR);
      p_all     = ^cw;
      fixed     = cw_ext;
      corrected = 1'b0;
      uncorr    = 1'b0;
      if (p_all) begin
         if (s_full == 8'd0) begin
            // Only the overall parity bit flipped; data is intact
            corrected = 1'b1;
         end else if (int'(s_full) <= K + NPAR) begin
            fixed     = cw_ext ^ (MAXCW'(1) << s_full);
            corrected = 1'b1;
         end else begin
            uncorr = 1'b1;
         end
      end else if (s_full != 8'd0) begin
         uncorr = 1'b1;
      end
      data_full = extract(fixed, K);
   end

   assign data        = data_full[K-1:0];
   assign syndrome    = s_full[NPAR-1:0];
   assign unused_bits = ^{data_full[MAXK-1:K], s_full[7:NPAR]};

endmodule

// File: rtl/adder_secded_pipe.sv
// adder_secded_pipe
//   Two-stage adder: stage 1 registers the SEC-DED encoded sum (carry-out
//   included), stage 2 registers the decoded/corrected result. Both stages
//   sit behind a valid/ready handshake. Saturating counters track corrected
//   and uncorrectable results.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     in_valid / in_ready  : operand handshake (a, b, c_in, inj_mask)
//     inj_mask             : XORed into the codeword at capture (fault injection)
//     out_valid / out_ready: result handshake
//     dec_sum              : decoded sum, MSB = carry
//     err_corrected        : single error corrected for this result
//     err_uncorr           : uncorrectable error for this result
//     syndrome             : Hamming syndrome for this result
//     clr_cnt              : synchronous counter clear (beats an increment)
//     corr_cnt, uncorr_cnt : saturating error counters
module adder_secded_pipe
   import adder_secded_pkg::*;
#(
   parameter  int NBIT  = 7,
   parameter  int CNTW  = 8,
   localparam int K     = NBIT + 1,
   localparam int NPAR  = calc_npar(K),
   localparam int NCODE = K + NPAR + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBIT-1:0]  a,
   input  logic [NBIT-1:0]  b,
   input  logic             c_in,
   input  logic [NCODE-1:0] inj_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBIT:0]    dec_sum,
   output logic             err_corrected,
   output logic             err_uncorr,
   output logic [NPAR-1:0]  syndrome,
   input  logic             clr_cnt,
   output logic [CNTW-1:0]  corr_cnt,
   output logic [CNTW-1:0]  uncorr_cnt
);

   logic             s1_valid_reg;
   logic [NCODE-1:0] s1_cw_reg;
   logic [K-1:0]     sum;
   logic [MAXCW-1:0] enc_full;
   logic             adv2;
   logic [K-1:0]     dec_data;
   logic [NPAR-1:0]  dec_syn;
   logic             dec_corr;
   logic             dec_uncorr;
   logic [1:0]       dec_flags;
   logic [CNTW-1:0]  cnt_reg [2];
   logic             unused_bits;

   assign sum         = K'(a) + K'(b) + K'(c_in);
   assign enc_full    = enc(MAXK'(sum), K);
   assign unused_bits = ^enc_full[MAXCW-1:NCODE];

   // Stage 2 can take a new entry when empty or being drained this cycle
   assign adv2     = !out_valid || out_ready;
   assign in_ready = !s1_valid_reg || adv2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_cw_reg    <= '0;
      end else if (in_valid && in_ready) begin
         s1_valid_reg <= 1'b1;
         s1_cw_reg    <= enc_full[NCODE-1:0] ^ inj_mask;
      end else if (adv2) begin
         s1_valid_reg <= 1'b0;
      end
   end

   secded_decoder #(.K(K)) u_dec (
      .cw        (s1_cw_reg),
      .data      (dec_data),
      .syndrome  (dec_syn),
      .corrected (dec_corr),
      .uncorr    (dec_uncorr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         dec_sum       <= '0;
         err_corrected <= 1'b0;
         err_uncorr    <= 1'b0;
         syndrome      <= '0;
      end else if (adv2) begin
         out_valid <= s1_valid_reg;
         // Bubbles keep the last result's data/flags; only out_valid drops
         if (s1_valid_reg) begin
            dec_sum       <= dec_data;
            err_corrected <= dec_corr;
            err_uncorr    <= dec_uncorr;
            syndrome      <= dec_syn;
         end
      end
   end

   // Index 0 counts corrected results, index 1 uncorrectable ones
   assign dec_flags = {dec_uncorr, dec_corr};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg[gi] <= '0;
            end else if (clr_cnt) begin
               cnt_reg[gi] <= '0;
            end else if (adv2 && s1_valid_reg && dec_flags[gi] && (cnt_reg[gi] != '1)) begin
               cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
         end
      end
   endgenerate

   assign corr_cnt   = cnt_reg[0];
   assign uncorr_cnt = cnt_reg[1];

endmodule

// File: tb/tb_adder_secded_pipe.sv
module tb_adder_secded_pipe;

   localparam int NBIT  = 7;
   localparam int CNTW  = 2;
   localparam int NPAR  = 4;
   localparam int NCODE = 13;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [NBIT-1:0]  a;
   logic [NBIT-1:0]  b;
   logic             c_in;
   logic [NCODE-1:0] inj_mask;
   logic             out_valid;
   logic             out_ready;
   logic [NBIT:0]    dec_sum;
   logic             err_corrected;
   logic             err_uncorr;
   logic [NPAR-1:0]  syndrome;
   logic             clr_cnt;
   logic [CNTW-1:0]  corr_cnt;
   logic [CNTW-1:0]  uncorr_cnt;

   int checks = 0;
   int errors = 0;

   adder_secded_pipe #(.NBIT(NBIT), .CNTW(CNTW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .a             (a),
      .b             (b),
      .c_in          (c_in),
      .inj_mask      (inj_mask),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .dec_sum       (dec_sum),
      .err_corrected (err_corrected),
      .err_uncorr    (err_uncorr),
      .syndrome      (syndrome),
      .clr_cnt       (clr_cnt),
      .corr_cnt      (corr_cnt),
      .uncorr_cnt    (uncorr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   // Present one operand set to an empty pipe; returns once the result is in stage 2
   task automatic send_one(input logic [6:0] av, input logic [6:0] bv, input logic cv,
                           input logic [12:0] mv);
      a = av; b = bv; c_in = cv; inj_mask = mv;
      in_valid = 1'b1; out_ready = 1'b1;
      tick;
      in_valid = 1'b0; inj_mask = '0;
      tick;
      #1;
      $display("txn a=%0d b=%0d c=%0d mask=%h -> sum=%0d corr=%0b uncorr=%0b syn=%0d",
               av, bv, cv, mv, dec_sum, err_corrected, err_uncorr, syndrome);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
      inj_mask = '0; out_ready = 1'b1; clr_cnt = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (dec_sum !== 8'd0) begin errors++; $display("FAIL reset_dec_sum: got %0d expected 0", dec_sum); end
      checks++; if ({err_corrected, err_uncorr} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {err_corrected, err_uncorr}); end
      checks++; if (syndrome !== 4'd0) begin errors++; $display("FAIL reset_syndrome: got %0d expected 0", syndrome); end
      checks++; if ({corr_cnt, uncorr_cnt} !== 4'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
      tick;
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      send_one(7'd100, 7'd27, 1'b0, 13'h0000);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b expected 1", out_valid); end
      checks++; if (dec_sum !== 8'd127) begin errors++; $display("FAIL basic_sum: got %0d expected 127", dec_sum); end
      checks++; if ({err_corrected, err_uncorr} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected 00", {err_corrected, err_uncorr}); end
      checks++; if (syndrome !== 4'd0) begin errors++; $display("FAIL basic_syndrome: got %0d expected 0", syndrome); end
      tick;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b expected 0", out_valid); end
   endtask

   task automatic test_errors;
      // Data bit 0 lives at position 3
      send_one(7'd127, 7'd127, 1'b1, 13'h0008);
      checks++; if (dec_sum !== 8'd255) begin errors++; $display("FAIL sec_pos3_sum: got %0d expected 255", dec_sum); end
      checks++; if ({err_corrected, err_uncorr} !== 2'b10) begin errors++; $display("FAIL sec_pos3_flags: got %b expected 10", {err_corrected, err_uncorr}); end
      checks++; if (syndrome !== 4'd3) begin errors++; $display("FAIL sec_pos3_syndrome: got %0d expected 3", syndrome); end
      checks++; if (corr_cnt !== 2'd1) begin errors++; $display("FAIL sec_pos3_corr_cnt: got %0d expected 1", corr_cnt); end
      // Overall parity bit only
      send_one(7'd5, 7'd9, 1'b0, 13'h0001);
      checks++; if (dec_sum !== 8'd14) begin errors++; $display("FAIL sec_p0_sum: got %0d expected 14", dec_sum); end
      checks++; if ({err_corrected, err_uncorr} !== 2'b10) begin errors++; $display("FAIL sec_p0_flags: got %b expected 10", {err_corrected, err_uncorr}); end
      checks++; if (syndrome !== 4'd0) begin errors++; $display("FAIL sec_p0_syndrome: got %0d expected 0", syndrome); end
      checks++; if (corr_cnt !== 2'd2) begin errors++; $display("FAIL sec_p0_corr_cnt: got %0d expected 2", corr_cnt); end
      // Positions 3 and 5 = data bits 0 and 1: raw data 127 -> 124
      send_one(7'd100, 7'd27, 1'b0, 13'h0028);
      checks++; if (dec_sum !== 8'd124) begin errors++; $display("FAIL ded_sum: got %0d expected 124", dec_sum); end
      checks++; if ({err_corrected, err_uncorr} !== 2'b01) begin errors++; $display("FAIL ded_flags: got %b expected 01", {err_corrected, err_uncorr}); end
      checks++; if (syndrome !== 4'd6) begin errors++; $display("FAIL ded_syndrome: got %0d expected 6", syndrome); end
      checks++; if (uncorr_cnt !== 2'd1) begin errors++; $display("FAIL ded_uncorr_cnt: got %0d expected 1", uncorr_cnt); end
      checks++; if (corr_cnt !== 2'd2) begin errors++; $display("FAIL ded_corr_cnt: got %0d expected 2", corr_cnt); end
      // Parity positions 1,4,8: odd weight, syndrome 13 beyond position 12
      send_one(7'd3, 7'd4, 1'b1, 13'h0112);
      checks++; if (dec_sum !== 8'd8) begin errors++; $display("FAIL oob_sum: got %0d expected 8", dec_sum); end
      checks++; if ({err_corrected, err_uncorr} !== 2'b01) begin errors++; $display("FAIL oob_flags: got %b expected 01", {err_corrected, err_uncorr}); end
      checks++; if (syndrome !== 4'd13) begin errors++; $display("FAIL oob_syndrome: got %0d expected 13", syndrome); end
      checks++; if (uncorr_cnt !== 2'd2) begin errors++; $display("FAIL oob_uncorr_cnt: got %0d expected 2", uncorr_cnt); end
      // Highest position 12 (data bit 7) is still correctable
      send_one(7'd100, 7'd27, 1'b0, 13'h1000);
      checks++; if (dec_sum !== 8'd127) begin errors++; $display("FAIL sec_pos12_sum: got %0d expected 127", dec_sum); end
      checks++; if ({err_corrected, err_uncorr} !== 2'b10) begin errors++; $display("FAIL sec_pos12_flags: got %b expected 10", {err_corrected, err_uncorr}); end
      checks++; if (syndrome !== 4'd12) begin errors++; $display("FAIL sec_pos12_syndrome: got %0d expected 12", syndrome); end
      checks++; if (corr_cnt !== 2'd3) begin errors++; $display("FAIL sec_pos12_corr_cnt: got %0d expected 3", corr_cnt); end
      tick;
   endtask

   task automatic test_back_to_back;
      logic [6:0] va [4];
      logic [6:0] vb [4];
      logic       vc [4];
      logic [7:0] ve [4];
      int ii;
      int oi;
      va = '{7'd1, 7'd10, 7'd50, 7'd127};
      vb = '{7'd2, 7'd20, 7'd60, 7'd1};
      vc = '{1'b0, 1'b1, 1'b0, 1'b0};
      ve = '{8'd3, 8'd31, 8'd110, 8'd128};
      ii = 0;
      oi = 0;
      inj_mask = '0;
      for (int cyc = 0; cyc < 20 && oi < 4; cyc++) begin
         tick;
         out_ready = !(cyc >= 2 && cyc <= 4);
         in_valid  = (ii < 4);
         if (ii < 4) begin
            a = va[ii]; b = vb[ii]; c_in = vc[ii];
         end
         #1;
         if (cyc >= 2 && cyc <= 4) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready cyc%0d: got %0b expected 0", cyc, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_out_valid cyc%0d: got %0b expected 1", cyc, out_valid); end
            checks++; if (dec_sum !== 8'd3) begin errors++; $display("FAIL b2b_stall_hold cyc%0d: got %0d expected 3", cyc, dec_sum); end
         end
         if (out_valid) begin
            checks++; if (dec_sum !== ve[oi]) begin errors++; $display("FAIL b2b_result%0d: got %0d expected %0d", oi, dec_sum, ve[oi]); end
            if (out_ready) begin
               $display("txn b2b result%0d sum=%0d", oi, dec_sum);
               oi++;
            end
         end
         if (in_valid && in_ready) ii++;
      end
      in_valid = 1'b0;
      checks++; if (oi != 4) begin errors++; $display("FAIL b2b_delivered: got %0d expected 4", oi); end
      tick;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got %0b expected 0", out_valid); end
   endtask

   task automatic test_counter_sat;
      do_reset;
      for (int i = 0; i < 5; i++) begin
         tick;
         a = 7'(i); b = 7'd1; c_in = 1'b0; inj_mask = 13'h0001;
         in_valid = 1'b1; out_ready = 1'b1;
      end
      tick;
      in_valid = 1'b0; inj_mask = '0;
      #1;
      checks++; if (corr_cnt !== 2'd3) begin errors++; $display("FAIL cnt_sat4: got %0d expected 3", corr_cnt); end
      tick;
      #1;
      checks++; if (corr_cnt !== 2'd3) begin errors++; $display("FAIL cnt_sat5: got %0d expected 3", corr_cnt); end
      checks++; if (dec_sum !== 8'd5) begin errors++; $display("FAIL cnt_last_sum: got %0d expected 5", dec_sum); end
      checks++; if (uncorr_cnt !== 2'd0) begin errors++; $display("FAIL cnt_uncorr_zero: got %0d expected 0", uncorr_cnt); end
      tick;
      a = 7'd6; b = 7'd1; c_in = 1'b0; inj_mask = 13'h0001; in_valid = 1'b1;
      tick;
      in_valid = 1'b0; inj_mask = '0; clr_cnt = 1'b1;
      #1;
      checks++; if (corr_cnt !== 2'd3) begin errors++; $display("FAIL cnt_pre_clr: got %0d expected 3", corr_cnt); end
      tick;
      clr_cnt = 1'b0;
      #1;
      $display("txn sixth result sum=%0d corr=%0b cnt=%0d", dec_sum, err_corrected, corr_cnt);
      checks++; if (corr_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clr_wins: got %0d expected 0", corr_cnt); end
      checks++; if ({out_valid, err_corrected} !== 2'b11) begin errors++; $display("FAIL cnt_sixth_flags: got %b expected 11", {out_valid, err_corrected}); end
      checks++; if (dec_sum !== 8'd7) begin errors++; $display("FAIL cnt_sixth_sum: got %0d expected 7", dec_sum); end
   endtask

   task automatic test_async_reset;
      tick;
      out_ready = 1'b0;
      a = 7'd2; b = 7'd2; c_in = 1'b0; inj_mask = 13'h0001; in_valid = 1'b1;
      tick;
      a = 7'd3; b = 7'd3;
      tick;
      in_valid = 1'b0; inj_mask = '0;
      #1;
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL arst_full: got %b expected 10", {out_valid, in_ready}); end
      checks++; if (corr_cnt !== 2'd1) begin errors++; $display("FAIL arst_pre_cnt: got %0d expected 1", corr_cnt); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %0b expected 0", out_valid); end
      checks++; if (corr_cnt !== 2'd0) begin errors++; $display("FAIL arst_corr_cnt: got %0d expected 0", corr_cnt); end
      checks++; if (dec_sum !== 8'd0) begin errors++; $display("FAIL arst_dec_sum: got %0d expected 0", dec_sum); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %0b expected 1", in_ready); end
      tick;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_stale%0d: got %0b expected 0", i, out_valid); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_errors;
      test_back_to_back;
      test_counter_sat;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
